// File: rtl/ffa_master_if.sv
// Command/response handshake bundle for the ffa_master initiator.
// The requester (control bus or sequencer) uses the master modport,
// ffa_master itself uses the slave modport.
interface ffa_master_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 3
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic [1:0]        rsp_status;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_status
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_status
    );
endinterface

// File: rtl/ffa_master.sv
// ffa_master: single-command initiator for the flip-flop register array.
// Sequences one-cycle rd/wr strobes, captures registered array outputs and
// returns one response per command. Optional macro READBACK_VERIFY_EN adds
// a readback after every write and reports VERIFY_MISMATCH on disagreement.
module ffa_master #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic                   clk,
    input  logic                   resetn,
    ffa_master_if.slave            bus,
    output logic                   arr_wr_o,
    output logic                   arr_rd_o,
    output logic [ADDR_W-1:0]      arr_addr_o,
    output logic [DATA_W-1:0]      arr_din_o,
    input  logic [DATA_W-1:0]      arr_dout_i,
    input  logic                   arr_error_i,
    input  logic [2**ADDR_W-1:0]   arr_status_i,
    output logic [15:0]            op_count_o,
    output logic [7:0]             err_count_o
);
    localparam int unsigned CNT_W = 16;
    localparam int unsigned ERR_W = 8;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WRITE   = 3'd1;
    localparam logic [2:0] S_WDONE   = 3'd2;
    localparam logic [2:0] S_READ    = 3'd3;
    localparam logic [2:0] S_CAPTURE = 3'd4;
    localparam logic [2:0] S_RESP    = 3'd5;
`ifdef READBACK_VERIFY_EN
    localparam logic [2:0] S_VRD     = 3'd6;
    localparam logic [2:0] S_VCAP    = 3'd7;
`endif

    localparam logic [1:0] ST_OK    = 2'b00;
    localparam logic [1:0] ST_UNWR  = 2'b01;
    localparam logic [1:0] ST_PERR  = 2'b10;
    localparam logic [1:0] ST_VMISS = 2'b11;

    logic [2:0]        state_q, state_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]        rsp_status_q, rsp_status_d;
    logic              arr_wr_q, arr_wr_d;
    logic              arr_rd_q, arr_rd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  op_count_q, op_count_d;
    logic [ERR_W-1:0]  err_count_q, err_count_d;
`ifdef READBACK_VERIFY_EN
    logic              perr_q, perr_d;
`endif

    // Next-state and next-register values; every output is a register
    always_comb begin
        state_d      = state_q;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_status_d = rsp_status_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        op_count_d   = op_count_q;
        err_count_d  = err_count_q;
`ifdef READBACK_VERIFY_EN
        perr_d       = perr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    addr_d = bus.cmd_addr;
                    if (bus.cmd_op) begin
                        wdata_d = bus.cmd_wdata;
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_WRITE: state_d = S_WDONE;
            S_WDONE: begin
`ifdef READBACK_VERIFY_EN
                perr_d  = arr_error_i;
                state_d = S_VRD;
`else
                rsp_rdata_d  = wdata_q;
                rsp_status_d = arr_error_i ? ST_PERR : ST_OK;
                state_d      = S_RESP;
`endif
            end
            S_READ: state_d = S_CAPTURE;
            S_CAPTURE: begin
                if (arr_error_i) begin
                    rsp_rdata_d  = arr_dout_i;
                    rsp_status_d = ST_PERR;
                end else if (!arr_status_i[addr_q]) begin
                    rsp_rdata_d  = '0;
                    rsp_status_d = ST_UNWR;
                end else begin
                    rsp_rdata_d  = arr_dout_i;
                    rsp_status_d = ST_OK;
                end
                state_d = S_RESP;
            end
`ifdef READBACK_VERIFY_EN
            S_VRD: state_d = S_VCAP;
            S_VCAP: begin
                rsp_rdata_d = arr_dout_i;
                if (perr_q || arr_error_i) begin
                    rsp_status_d = ST_PERR;
                end else if ((arr_dout_i != wdata_q) || !arr_status_i[addr_q]) begin
                    rsp_status_d = ST_VMISS;
                end else begin
                    rsp_status_d = ST_OK;
                end
                state_d = S_RESP;
            end
`endif
            S_RESP: begin
                if (bus.rsp_ready) begin
                    op_count_d = op_count_q + CNT_W'(1);
                    if ((rsp_status_q != ST_OK) && (err_count_q != '1)) begin
                        err_count_d = err_count_q + ERR_W'(1);
                    end
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        cmd_ready_d = (state_d == S_IDLE);
        arr_wr_d    = (state_d == S_WRITE);
`ifdef READBACK_VERIFY_EN
        arr_rd_d    = (state_d == S_READ) || (state_d == S_VRD);
`else
        arr_rd_d    = (state_d == S_READ);
`endif
        rsp_valid_d = (state_d == S_RESP);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            cmd_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_status_q <= ST_OK;
            arr_wr_q     <= 1'b0;
            arr_rd_q     <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            op_count_q   <= '0;
            err_count_q  <= '0;
`ifdef READBACK_VERIFY_EN
            perr_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cmd_ready_q  <= cmd_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_status_q <= rsp_status_d;
            arr_wr_q     <= arr_wr_d;
            arr_rd_q     <= arr_rd_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            op_count_q   <= op_count_d;
            err_count_q  <= err_count_d;
`ifdef READBACK_VERIFY_EN
            perr_q       <= perr_d;
`endif
        end
    end

    assign bus.cmd_ready  = cmd_ready_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_rdata  = rsp_rdata_q;
    assign bus.rsp_status = rsp_status_q;
    assign arr_wr_o       = arr_wr_q;
    assign arr_rd_o       = arr_rd_q;
    assign arr_addr_o     = addr_q;
    assign arr_din_o      = wdata_q;
    assign op_count_o     = op_count_q;
    assign err_count_o    = err_count_q;

endmodule
